// File: rtl/prog_ins_memory_if.sv
// -----------------------------------------------------------------------------
// prog_ins_memory_if
// Bundles the fetch and program-load signals of the instruction memory.
//   fetch : fetchReq/fetchAd in, fetchReady/ins/insValid/adErr out
//   load  : ldStart/ldBase/ldValid/ldData/ldLast/clrReq in,
//           ldBusy/ldCount/ldOverflow out
// The slave modport is the memory; the master modport is the CPU or host side.
// -----------------------------------------------------------------------------
interface prog_ins_memory_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16
);
   logic              fetchReq;
   logic [ADDR_W-1:0] fetchAd;
   logic              fetchReady;
   logic [DATA_W-1:0] ins;
   logic              insValid;
   logic              adErr;
   logic              ldStart;
   logic [ADDR_W-1:0] ldBase;
   logic              ldValid;
   logic [DATA_W-1:0] ldData;
   logic              ldLast;
   logic              clrReq;
   logic              ldBusy;
   logic [ADDR_W:0]   ldCount;
   logic              ldOverflow;

   modport slave (
      input  fetchReq, fetchAd, ldStart, ldBase, ldValid, ldData, ldLast, clrReq,
      output fetchReady, ins, insValid, adErr, ldBusy, ldCount, ldOverflow
   );

   modport master (
      output fetchReq, fetchAd, ldStart, ldBase, ldValid, ldData, ldLast, clrReq,
      input  fetchReady, ins, insValid, adErr, ldBusy, ldCount, ldOverflow
   );
endinterface

// File: rtl/prog_ins_memory.sv
// -----------------------------------------------------------------------------
// prog_ins_memory
// Runtime-loadable instruction memory. Fetches return one word per request
// with one cycle of registered latency; a load port streams a program in.
// After reset (or a clear request) every location is swept to zero.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : prog_ins_memory_if.slave (fetch and load signals)
// -----------------------------------------------------------------------------
module prog_ins_memory #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4096
) (
   input  logic                clk,
   input  logic                rst_n,
   prog_ins_memory_if.slave    bus
);

   typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_e;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

   state_e            state_q, state_d;
   // One pointer serves as the clear sweep pointer in CLEAR and the write
   // pointer in LOAD; it is one bit wider than the address so a load running
   // past the top of memory keeps counting instead of wrapping.
   logic [ADDR_W:0]   ptr_q, ptr_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] ins_q;
   logic              ins_vld_q, ad_err_q;
   logic              ready_q, busy_q;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic              fetch_acc;
   logic              fetch_in;

   assign fetch_acc = ready_q && bus.fetchReq;
   assign fetch_in  = {1'b0, bus.fetchAd} < DEPTH_C;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      we      = 1'b0;
      waddr   = ptr_q[ADDR_W-1:0];
      wdata   = '0;
      case (state_q)
         CLEAR: begin
            we = 1'b1;
            if (ptr_q == LAST_C) state_d = IDLE;
            else                 ptr_d   = ptr_q + ONE_C;
         end
         IDLE: begin
            if (bus.clrReq) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end else if (bus.ldStart) begin
               state_d = LOAD;
               ptr_d   = {1'b0, bus.ldBase};
               cnt_d   = '0;
               ovf_d   = 1'b0;
            end
         end
         LOAD: begin
            if (bus.ldValid) begin
               if (ptr_q < DEPTH_C) begin
                  we    = 1'b1;
                  wdata = bus.ldData;
                  cnt_d = cnt_q + ONE_C;
               end else begin
                  ovf_d = 1'b1;
               end
               // Saturate rather than wrap back into valid addresses.
               if (ptr_q != '1) ptr_d = ptr_q + ONE_C;
               if (bus.ldLast)  state_d = IDLE;
            end
         end
         default: begin
            state_d = CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= CLEAR;
         ptr_q     <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         ins_q     <= '0;
         ins_vld_q <= 1'b0;
         ad_err_q  <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         // Status flags decode the next state so they line up with state_q.
         ready_q   <= (state_d == IDLE);
         busy_q    <= (state_d != IDLE);
         ins_vld_q <= fetch_acc;
         ad_err_q  <= fetch_acc && !fetch_in;
         // A fetch accepted alongside clrReq/ldStart reads the old contents,
         // since the memory write of the same edge lands after this read.
         if (fetch_acc) ins_q <= fetch_in ? mem[bus.fetchAd] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign bus.fetchReady = ready_q;
   assign bus.ins        = ins_q;
   assign bus.insValid   = ins_vld_q;
   assign bus.adErr      = ad_err_q;
   assign bus.ldBusy     = busy_q;
   assign bus.ldCount    = cnt_q;
   assign bus.ldOverflow = ovf_q;

endmodule

// File: doc/prog_ins_memory.md
# prog_ins_memory

Parametrised, runtime-loadable instruction memory for the multi-cycle CPU: the fetch side returns one instruction word per request with one-cycle registered latency and a valid strobe, and a load port streams a program into memory from a host or test harness. After reset the block sweeps every location to zero, so unloaded addresses read as `CLA` (all-zero opcode). It sits between the controller's PC and the instruction register, and replaces fixed, initial-block program images with loads issued at run time.

## Interface
- `ADDR_W`, 12, fetch/load address width
- `DATA_W`, 16, instruction word width
- `DEPTH`, 4096, implemented words; must satisfy DEPTH ≤ 2^ADDR_W
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `fetchReq`  in  1  fetch request; accepted only when `fetchReady`=1
- `fetchAd`  in  ADDR_W  fetch address
- `fetchReady`  out  1  high exactly when state is IDLE
- `ins`  out  DATA_W  registered instruction word
- `insValid`  out  1  one-cycle pulse, `ins` valid
- `adErr`  out  1  one-cycle pulse with `insValid`, fetch address ≥ DEPTH
- `ldStart`  in  1  begin load; sampled in IDLE only
- `ldBase`  in  ADDR_W  first load address, sampled with `ldStart`
- `ldValid`  in  1  `ldData` valid this cycle (LOAD state only)
- `ldData`  in  DATA_W  word to write
- `ldLast`  in  1  qualifies final word; meaningful only with `ldValid`
- `clrReq`  in  1  re-clear memory; sampled in IDLE only
- `ldBusy`  out  1  state ≠ IDLE
- `ldCount`  out  ADDR_W+1  words written by current/last load
- `ldOverflow`  out  1  sticky: a load word addressed ≥ DEPTH was dropped

## Operation
- States: CLEAR, IDLE, LOAD. Reset enters CLEAR with clear pointer 0.
- CLEAR: write 0 to location pointer, one per cycle. After pointer DEPTH-1 is written, go to IDLE. Duration is exactly DEPTH cycles.
- IDLE, priority `clrReq` > `ldStart`:
  - `clrReq` → CLEAR.
  - `ldStart` → LOAD; capture write pointer ← `ldBase`; clear `ldCount` and `ldOverflow`.
- A fetch accepted in the same IDLE cycle as `clrReq`/`ldStart` completes normally and returns pre-clear/pre-load contents.
- LOAD:
  - Each `ldValid` cycle: if pointer < DEPTH, write `ldData` and increment `ldCount`; otherwise drop the word and set `ldOverflow`.
  - Pointer increments on every `ldValid`; no wrap; the pointer register is ADDR_W+1 bits.
  - `ldValid` with `ldLast` → IDLE next cycle. `ldLast` without `ldValid` is ignored.
  - Gaps in `ldValid` are allowed.
- `ldValid` outside LOAD, including the `ldStart` cycle, is ignored. `fetchReq` while `fetchReady`=0 is ignored: no response.
- Fetch: accepted request reads `mem[fetchAd]`; response is registered.
- If `fetchAd` ≥ DEPTH: `ins`←0, `adErr`=1, `insValid`=1.
- `ins` holds its last value between responses.

## Timing
- Reset values: `ins`=0, `insValid`=0, `adErr`=0, `ldCount`=0, `ldOverflow`=0, `ldBusy`=1, `fetchReady`=0.
- Fetch latency 1: request at edge N → `ins`/`insValid` valid after edge N+1. Back-to-back requests give one word per cycle.
- `fetchReady` is a registered decode of state, with no combinational path from inputs.
- Load writes commit at the edge sampling `ldValid`. A fetch to that address is possible only after the return to IDLE, so there are no read/write hazards.
- `ldCount`/`ldOverflow` hold after LOAD until the next `ldStart`; `clrReq` does not alter them.
- `rst_n` asserted mid-LOAD or mid-CLEAR: all outputs immediately take reset values, the load is aborted, and a full CLEAR restarts after `rst_n` deasserts.

## Test plan
- Reset, ADDR_W=5, DEPTH=16: `fetchReady`=0 for 16 cycles after `rst_n` rises, then 1. Fetch 7 → `ins`=0x0000, `insValid` pulse next cycle, `adErr`=0.
- Load at base 0: 0x7000, 0x3000, 0x900A, with `ldLast` on the third word and one idle cycle between words 1 and 2 → `ldCount`=3, `ldOverflow`=0. Back-to-back fetch 0, 1, 2 → 0x7000, 0x3000, 0x900A on three consecutive cycles.
- `fetchReq` held high throughout LOAD → no `insValid` until after IDLE. Same-cycle `ldStart`+fetch 1 in IDLE → old word returned.
- Overflow: base 14, four words 0xA, 0xB, 0xC, 0xD → locations 14/15 = 0xA/0xB, `ldCount`=2, `ldOverflow`=1. Next `ldStart` clears `ldOverflow`.
- Fetch 20 → `ins`=0, `insValid`=1, `adErr`=1 for one cycle. `clrReq` then fetch 0 → 0x0000 after 16 busy cycles.
- Assert `rst_n` after the second word of a load at base 4 → outputs reset immediately, CLEAR reruns, fetch 4 → 0x0000.
